// File: rtl/uart_mem_loader_pkg.sv
// uart_mem_loader_pkg: command/response byte codes and FSM state encoding
// shared by the UART memory loader and its response serializer.
package uart_mem_loader_pkg;

  // Host command bytes (first byte of each packet)
  localparam logic [7:0] CMD_WRITE      = 8'h57; // 'W' addr[4] data[4]
  localparam logic [7:0] CMD_READ       = 8'h52; // 'R' addr[4]
  localparam logic [7:0] CMD_HOLD       = 8'h48; // 'H' hold CPU in reset
  localparam logic [7:0] CMD_GO         = 8'h47; // 'G' release CPU
  localparam logic [7:0] CMD_WRITE_NEXT = 8'h77; // 'w' data[4] at last_addr+4

  // Response bytes
  localparam logic [7:0] RSP_OK      = 8'h4B; // 'K'
  localparam logic [7:0] RSP_ERR     = 8'h3F; // '?'
  localparam logic [7:0] RSP_TIMEOUT = 8'h54; // 'T'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/uart_mem_loader_txser.sv
// uart_mem_loader_txser: serializes a 1..4 byte response, LSB first, onto a
// valid/ready byte port.
//   load/load_data/load_len : one-cycle request to start a new response
//   tx_valid/tx_data        : registered byte output, held until tx_ready
//   tx_ready                : downstream accepts on tx_valid && tx_ready
//   done                    : combinational, high on the last byte's handshake
module uart_mem_loader_txser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_len,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [23:0] rest;  // bytes still to send, next one in [7:0]
  logic [1:0]  left;  // bytes remaining after the one on tx_data

  assign done = tx_valid && tx_ready && (left == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      rest     <= 24'h0;
      left     <= 2'd0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data[7:0];
      rest     <= load_data[31:8];
      left     <= 2'(load_len - 3'd1);
    end else if (tx_valid && tx_ready) begin
      if (left == 2'd0) begin
        tx_valid <= 1'b0;
      end else begin
        tx_data <= rest[7:0];
        rest    <= {8'h00, rest[23:8]};
        left    <= left - 2'd1;
      end
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: turns host command packets from a UART byte stream into
// single native-bus transactions and returns response bytes to a UART TX.
// Also owns the CPU hold line used while firmware is loaded.
//   clk, rst               : clock, asynchronous active-high reset
//   rx_valid/rx_data       : received byte strobe
//   tx_valid/tx_data/
//   tx_ready               : response byte stream
//   mem_valid/mem_addr/
//   mem_wdata/mem_wstrb/
//   mem_ready/mem_rdata    : bus initiator port (wstrb F = write, 0 = read)
//   cpu_hold               : high keeps the CPU in reset
//   overrun                : sticky, a byte arrived while busy and was dropped
// Build option: define LOADER_AUTOINC_EN to add the 'w' (write to
// last_addr+4) command; otherwise 0x77 is answered with '?'.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT       = 1024,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        cpu_hold,
  output logic        overrun
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  cnt;
  logic [7:0]  cmd;
  logic [31:0] addr_sh;
  logic [31:0] data_sh;
  logic [15:0] tmo_cnt;
  logic        resp_load;
  logic [31:0] resp_data;
  logic [2:0]  resp_len;
  logic        resp_done;
  logic [31:0] addr_nxt;
  logic [31:0] data_nxt;
`ifdef LOADER_AUTOINC_EN
  logic [31:0] last_addr;
`endif

  // Little-endian fields: each new byte enters at the top, so after four
  // bytes the first one received sits in [7:0].
  assign addr_nxt = {rx_data, addr_sh[31:8]};
  assign data_nxt = {rx_data, data_sh[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 2'd0;
      cmd       <= 8'h00;
      addr_sh   <= 32'h0;
      data_sh   <= 32'h0;
      tmo_cnt   <= 16'h0;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      resp_load <= 1'b0;
      resp_data <= 32'h0;
      resp_len  <= 3'd1;
      cpu_hold  <= HOLD_AT_RESET;
      overrun   <= 1'b0;
`ifdef LOADER_AUTOINC_EN
      last_addr <= 32'h0;
`endif
    end else begin
      resp_load <= 1'b0;
      // The host must wait for the response; anything sent meanwhile is lost.
      if (rx_valid && (state == ST_BUS || state == ST_RESP)) overrun <= 1'b1;

      case (state)
        ST_IDLE: if (rx_valid) begin
          cmd <= rx_data;
          cnt <= 2'd0;
          case (rx_data)
            CMD_WRITE, CMD_READ: state <= ST_ADDR;
            CMD_HOLD, CMD_GO: begin
              cpu_hold  <= (rx_data == CMD_HOLD);
              state     <= ST_RESP;
              resp_load <= 1'b1;
              resp_data <= {24'h0, RSP_OK};
              resp_len  <= 3'd1;
            end
`ifdef LOADER_AUTOINC_EN
            CMD_WRITE_NEXT: state <= ST_DATA;
`endif
            default: begin
              state     <= ST_RESP;
              resp_load <= 1'b1;
              resp_data <= {24'h0, RSP_ERR};
              resp_len  <= 3'd1;
            end
          endcase
        end

        ST_ADDR: if (rx_valid) begin
          addr_sh <= addr_nxt;
          cnt     <= cnt + 2'd1;  // wraps to 0 for the DATA phase
          if (cnt == 2'd3) begin
            if (cmd == CMD_WRITE) begin
              state <= ST_DATA;
            end else begin
              state     <= ST_BUS;
              mem_valid <= 1'b1;
              mem_addr  <= {addr_nxt[31:2], 2'b00};
              mem_wstrb <= 4'h0;
              tmo_cnt   <= 16'h0;
`ifdef LOADER_AUTOINC_EN
              last_addr <= {addr_nxt[31:2], 2'b00};
`endif
            end
          end
        end

        ST_DATA: if (rx_valid) begin
          data_sh <= data_nxt;
          cnt     <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state     <= ST_BUS;
            mem_valid <= 1'b1;
            mem_wdata <= data_nxt;
            mem_wstrb <= 4'hF;
            tmo_cnt   <= 16'h0;
`ifdef LOADER_AUTOINC_EN
            if (cmd == CMD_WRITE_NEXT) begin
              mem_addr  <= last_addr + 32'd4;  // natural 32-bit wrap
              last_addr <= last_addr + 32'd4;
            end else begin
              mem_addr  <= {addr_sh[31:2], 2'b00};
              last_addr <= {addr_sh[31:2], 2'b00};
            end
`else
            mem_addr  <= {addr_sh[31:2], 2'b00};
`endif
          end
        end

        ST_BUS: begin
          // mem_ready wins over an expiring timeout on the same cycle.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= ST_RESP;
            resp_load <= 1'b1;
            if (mem_wstrb == 4'h0) begin
              resp_data <= mem_rdata;
              resp_len  <= 3'd4;
            end else begin
              resp_data <= {24'h0, RSP_OK};
              resp_len  <= 3'd1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            mem_valid <= 1'b0;
            state     <= ST_RESP;
            resp_load <= 1'b1;
            resp_data <= {24'h0, RSP_TIMEOUT};
            resp_len  <= 3'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        // Still RESP on the last handshake, so a byte arriving then is dropped.
        ST_RESP: if (resp_done) state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_mem_loader_txser u_txser (
    .clk       (clk),
    .rst       (rst),
    .load      (resp_load),
    .load_data (resp_data),
    .load_len  (resp_len),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .done      (resp_done)
  );

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: randomized command stream against a packet-level
// reference model (responder memory, hold/overrun flags, expected bytes).
module tb_uart_mem_loader;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_hold;
  logic        overrun;

  always #5 clk = ~clk;

  uart_mem_loader #(.TIMEOUT(TMO), .HOLD_AT_RESET(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .cpu_hold  (cpu_hold),
    .overrun   (overrun)
  );

  // Reference model state
  logic [31:0] mem_m [logic [31:0]];
  logic [7:0]  exp_q [$];
  logic        exp_hold;
  logic        exp_ovr;
  logic [31:0] last_addr_m;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_cmd(input logic [7:0] b);
`ifdef LOADER_AUTOINC_EN
    return b == 8'h57 || b == 8'h52 || b == 8'h48 || b == 8'h47 || b == 8'h77;
`else
    return b == 8'h57 || b == 8'h52 || b == 8'h48 || b == 8'h47;
`endif
  endfunction

  // All tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic collect();
    int idx = 0;
    int cyc = 0;
    while (idx < exp_q.size() && cyc < 300) begin
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) begin
        chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q[idx]});
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
    chk("tx_count", idx, exp_q.size());
    chk("tx_idle", {31'h0, tx_valid}, 32'h0);
  endtask

  task automatic reset_dut();
    rst = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    chk("rst_cpu_hold", {31'h0, cpu_hold}, 32'h1);
    rst = 1'b0;
    exp_hold = 1'b1; exp_ovr = 1'b0; last_addr_m = 32'h0;
    @(negedge clk);
  endtask

  // One full packet: send, serve the bus (waits >= TMO means never ready),
  // collect and check the response.
  task automatic run_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input bit inject);
    bit          bus = 1'b0;
    bit          wr  = 1'b0;
    logic [31:0] ea  = 32'h0;
    logic [31:0] rd;
    int          n;
    exp_q.delete();
    send_byte(op);
    case (op)
      8'h57: begin send_word(a); send_word(d); bus = 1; wr = 1; ea = {a[31:2], 2'b00}; end
      8'h52: begin send_word(a); bus = 1; ea = {a[31:2], 2'b00}; end
`ifdef LOADER_AUTOINC_EN
      8'h77: begin send_word(d); bus = 1; wr = 1; ea = last_addr_m + 32'd4; end
`endif
      8'h48: begin exp_hold = 1'b1; exp_q.push_back(8'h4B); end
      8'h47: begin exp_hold = 1'b0; exp_q.push_back(8'h4B); end
      default: exp_q.push_back(8'h3F);
    endcase
    if (bus) begin
      chk("bus_latency", {31'h0, mem_valid}, 32'h1);
      chk("bus_addr", mem_addr, ea);
      chk("bus_wstrb", {28'h0, mem_wstrb}, wr ? 32'hF : 32'h0);
      if (wr) chk("bus_wdata", mem_wdata, d);
      last_addr_m = ea;
      if (waits >= TMO) begin
        n = 0;
        while (mem_valid && n < 100) begin n++; @(negedge clk); end
        chk("tmo_len", n, TMO);
        exp_q.push_back(8'h54);
      end else begin
        for (int i = 0; i < waits; i++) begin
          chk("hold_valid", {31'h0, mem_valid}, 32'h1);
          chk("hold_addr", mem_addr, ea);
          rx_valid = inject && (i == 0);
          rx_data  = 8'($urandom);
          if (inject && i == 0) exp_ovr = 1'b1;
          @(negedge clk);
        end
        rx_valid = 1'b0;
        if (!mem_m.exists(ea)) mem_m[ea] = $urandom;
        rd = mem_m[ea];
        mem_ready = 1'b1;
        mem_rdata = wr ? 32'($urandom) : rd;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("valid_drop", {31'h0, mem_valid}, 32'h0);
        if (wr) begin
          mem_m[ea] = d;
          exp_q.push_back(8'h4B);
        end else begin
          for (int i = 0; i < 4; i++) exp_q.push_back(rd[8*i +: 8]);
        end
      end
    end
    collect();
    chk("cpu_hold", {31'h0, cpu_hold}, {31'h0, exp_hold});
    chk("overrun", {31'h0, overrun}, {31'h0, exp_ovr});
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] a;
    int          w;
    int          n;

    reset_dut();

    // Hold / go / unknown
    run_cmd(8'h47, 0, 0, 0, 0);
    run_cmd(8'h48, 0, 0, 0, 0);
    run_cmd(8'h00, 0, 0, 0, 0);

    // Write, then read with unaligned host address and a dropped byte in BUS
    run_cmd(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);
    mem_m[32'h10] = 32'h1234_5678;  // responder content changed behind us
    run_cmd(8'h52, 32'h0000_0013, 0, 3, 1);

    // Timeout, then IDLE must take the next command
    run_cmd(8'h52, 32'h0300_0000, 0, 100, 0);
    run_cmd(8'h47, 0, 0, 0, 0);

`ifdef LOADER_AUTOINC_EN
    run_cmd(8'h57, 32'hFFFF_FFFC, 32'hCAFE_0001, 1, 0);
    run_cmd(8'h77, 0, 32'h0000_0001, 0, 0);
`endif

    // Random command stream
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0, 1: op = 8'h57;
        2:    op = 8'h52;
        3:    op = $urandom_range(0, 1) ? 8'h48 : 8'h47;
        4:    begin
                op = 8'($urandom);
                while (is_cmd(op)) op = 8'($urandom);
              end
        default: begin
`ifdef LOADER_AUTOINC_EN
                op = 8'h77;
`else
                op = 8'h52;
`endif
              end
      endcase
      a = $urandom_range(0, 1) ? {27'h0, 5'($urandom)} : $urandom;
      w = ($urandom_range(0, 11) == 0) ? 100 : int'($urandom_range(0, 4));
      run_cmd(op, a, $urandom, w, (w >= 1 && w < TMO) && ($urandom_range(0, 4) == 0));
    end

    // Reset while a response is pending: outputs drop without a clock edge
    if (!exp_ovr) run_cmd(8'h52, 32'h8, 0, 2, 1);
    chk("ovr_before_rst", {31'h0, overrun}, 32'h1);
    send_byte(8'h47);
    n = 0;
    while (!tx_valid && n < 20) begin n++; @(negedge clk); end
    chk("resp_pending", {31'h0, tx_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("async_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("async_overrun", {31'h0, overrun}, 32'h0);
    chk("async_cpu_hold", {31'h0, cpu_hold}, 32'h1);
    @(negedge clk);
    reset_dut();

    // Partial packet is discarded by reset
    send_byte(8'h57);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_hold = 1'b1; exp_ovr = 1'b0; last_addr_m = 32'h0;
    @(negedge clk);
    run_cmd(8'h47, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
